// File: rtl/idli_ser_if.sv
// idli_ser_if: word/nibble handshake bundle between core logic and the nibble serializer
interface idli_ser_if;
  logic [15:0] i_ser_tx_data;
  logic        i_ser_tx_valid;
  logic        o_ser_tx_ready;
  logic [3:0]  o_ser_tx_nibble;
  logic        o_ser_tx_active;
  logic [3:0]  i_ser_rx_nibble;
  logic        i_ser_rx_en;
  logic [15:0] o_ser_rx_data;
  logic        o_ser_rx_valid;
  modport master (
    output i_ser_tx_data, i_ser_tx_valid, i_ser_rx_nibble, i_ser_rx_en,
    input  o_ser_tx_ready, o_ser_tx_nibble, o_ser_tx_active, o_ser_rx_data, o_ser_rx_valid
  );
  modport slave (
    input  i_ser_tx_data, i_ser_tx_valid, i_ser_rx_nibble, i_ser_rx_en,
    output o_ser_tx_ready, o_ser_tx_nibble, o_ser_tx_active, o_ser_rx_data, o_ser_rx_valid
  );
endinterface

// File: rtl/idli_ser_m.sv
// idli_ser_m: 16b<->4b nibble serializer/deserializer aligned to the core cycle counter,
// with a sticky monitor for counter/last-cycle protocol violations.
module idli_ser_m #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       i_ser_gck,
  input  logic       i_ser_rst_n,
  input  logic [1:0] i_ser_ctr,
  input  logic       i_ser_ctr_last_cycle,
  idli_ser_if.slave  bus,
  output logic       o_ser_err
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, rx_open_q, rx_open_d, rx_valid_q, rx_valid_d, err_q, err_d, chk_q;
  logic [11:0]   rx_sh_q, rx_sh_d;
  logic [15:0]   rx_data_q, rx_data_d, head;
  logic [1:0]    prev_ctr_q;
  logic          empty, push, pop, active;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty               = cnt_q == '0;
  assign bus.o_ser_tx_ready  = cnt_q != CW'(FIFO_DEPTH);
  assign push                = bus.i_ser_tx_valid & bus.o_ser_tx_ready;
  assign pop                 = (i_ser_ctr == 2'd3) & busy_q;
  assign head                = mem_q[rd_ptr_q];
  assign active              = busy_q | ((i_ser_ctr == 2'd0) & !empty);
  assign bus.o_ser_tx_active = active;
  assign bus.o_ser_tx_nibble = active ? head[{i_ser_ctr, 2'b00} +: 4] : 4'h0;
  assign bus.o_ser_rx_data   = rx_data_q;
  assign bus.o_ser_rx_valid  = rx_valid_q;
  assign o_ser_err           = err_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.i_ser_tx_data;
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    busy_d   = pop ? 1'b0 : ((i_ser_ctr == 2'd0) & !empty) ? 1'b1 : busy_q;
    rx_sh_d    = rx_sh_q;
    rx_open_d  = rx_open_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    // A frame opens only at position 0; any dropout later in the frame abandons it.
    if (i_ser_ctr == 2'd0) begin
      rx_open_d     = bus.i_ser_rx_en;
      rx_sh_d[3:0]  = bus.i_ser_rx_nibble;
    end else if (rx_open_q & bus.i_ser_rx_en) begin
      if (i_ser_ctr == 2'd3) begin
        rx_data_d  = {bus.i_ser_rx_nibble, rx_sh_q};
        rx_valid_d = 1'b1;
        rx_open_d  = 1'b0;
      end else begin
        rx_sh_d[{i_ser_ctr, 2'b00} +: 4] = bus.i_ser_rx_nibble;
      end
    end else begin
      rx_open_d = 1'b0;
    end
    err_d = err_q | (i_ser_ctr_last_cycle != (i_ser_ctr == 2'd3))
                  | (chk_q & (i_ser_ctr != prev_ctr_q + 2'd1));
  end
  always_ff @(posedge i_ser_gck or negedge i_ser_rst_n) begin
    if (!i_ser_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rx_sh_q    <= '0;
      rx_open_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      chk_q      <= 1'b0;
      prev_ctr_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rx_sh_q    <= rx_sh_d;
      rx_open_q  <= rx_open_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      chk_q      <= 1'b1;
      prev_ctr_q <= i_ser_ctr;
    end
  end
endmodule

// File: tb/tb_idli_ser_m.sv
// tb_idli_ser_m: directed vectors for the nibble serializer, deserializer and counter monitor
module tb_idli_ser_m;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctr = 2'd0;
  logic       last = 1'b0;
  logic       err;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] t1 [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
  logic [3:0] t2 [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
  logic [3:0] r3 [4] = '{4'hF, 4'h0, 4'hE, 4'h1};
  idli_ser_if bus ();
  idli_ser_m #(.FIFO_DEPTH(2)) dut (
    .i_ser_gck           (clk),
    .i_ser_rst_n         (rst_n),
    .i_ser_ctr           (ctr),
    .i_ser_ctr_last_cycle(last),
    .bus                 (bus),
    .o_ser_err           (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ctr  = ctr + 2'd1;
    last = (ctr == 2'd3);
  endtask
  initial begin
    bus.i_ser_tx_data   = '0;
    bus.i_ser_tx_valid  = 1'b0;
    bus.i_ser_rx_nibble = '0;
    bus.i_ser_rx_en     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 16'(bus.o_ser_tx_ready), 16'd1);
    chk("rst_active", 16'(bus.o_ser_tx_active), 16'd0);
    chk("rst_nibble", 16'(bus.o_ser_tx_nibble), 16'd0);
    chk("rst_rx_data", bus.o_ser_rx_data, 16'h0000);
    chk("rst_rx_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // single word pushed mid-frame goes out in the next frame, LSB nibble first
    tick();
    bus.i_ser_tx_data = 16'hA5C3; bus.i_ser_tx_valid = 1'b1;
    @(negedge clk); chk("t1_ready", 16'(bus.o_ser_tx_ready), 16'd1);
    tick(); bus.i_ser_tx_valid = 1'b0;
    @(negedge clk); chk("t1_idle2", 16'(bus.o_ser_tx_active), 16'd0);
    tick();
    @(negedge clk); chk("t1_idle3", 16'(bus.o_ser_tx_active), 16'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("t1_active", 16'(bus.o_ser_tx_active), 16'd1);
      chk("t1_nibble", 16'(bus.o_ser_tx_nibble), 16'(t1[k]));
    end
    tick();
    @(negedge clk);
    chk("t1_done", 16'(bus.o_ser_tx_active), 16'd0);
    chk("t1_done_nib", 16'(bus.o_ser_tx_nibble), 16'd0);
    // two words fill the FIFO and stream back-to-back
    tick(); bus.i_ser_tx_data = 16'h1234; bus.i_ser_tx_valid = 1'b1;
    @(negedge clk); chk("t2_ready0", 16'(bus.o_ser_tx_ready), 16'd1);
    tick(); bus.i_ser_tx_data = 16'h5678;
    @(negedge clk); chk("t2_ready1", 16'(bus.o_ser_tx_ready), 16'd1);
    tick(); bus.i_ser_tx_valid = 1'b0;
    @(negedge clk);
    chk("t2_full", 16'(bus.o_ser_tx_ready), 16'd0);
    chk("t2_wait", 16'(bus.o_ser_tx_active), 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      chk("t2_active", 16'(bus.o_ser_tx_active), 16'd1);
      chk("t2_nibble", 16'(bus.o_ser_tx_nibble), 16'(t2[i]));
      chk("t2_ready", 16'(bus.o_ser_tx_ready), (i >= 4) ? 16'd1 : 16'd0);
    end
    tick();
    @(negedge clk); chk("t2_done", 16'(bus.o_ser_tx_active), 16'd0);
    // complete inbound frame
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      bus.i_ser_rx_en = 1'b1; bus.i_ser_rx_nibble = r3[k];
      @(negedge clk); chk("t3_no_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    end
    tick(); bus.i_ser_rx_en = 1'b0;
    @(negedge clk);
    chk("t3_valid", 16'(bus.o_ser_rx_valid), 16'd1);
    chk("t3_data", bus.o_ser_rx_data, 16'h1E0F);
    tick();
    @(negedge clk); chk("t3_pulse", 16'(bus.o_ser_rx_valid), 16'd0);
    // aborted frame, then a frame started off-position
    tick(); tick();
    tick(); bus.i_ser_rx_en = 1'b1; bus.i_ser_rx_nibble = 4'h7;
    tick();
    tick(); bus.i_ser_rx_en = 1'b0;
    tick(); bus.i_ser_rx_en = 1'b1;
    tick(); bus.i_ser_rx_en = 1'b0;
    @(negedge clk);
    chk("t4_abort_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    chk("t4_abort_data", bus.o_ser_rx_data, 16'h1E0F);
    tick(); bus.i_ser_rx_en = 1'b1; bus.i_ser_rx_nibble = 4'h2;
    tick();
    tick();
    tick(); bus.i_ser_rx_en = 1'b0;
    @(negedge clk); chk("t4_late_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    tick();
    @(negedge clk);
    chk("t4_late_valid2", 16'(bus.o_ser_rx_valid), 16'd0);
    chk("t4_late_data", bus.o_ser_rx_data, 16'h1E0F);
    // reset in the middle of a TX word and an RX frame
    bus.i_ser_tx_data = 16'hB00B; bus.i_ser_tx_valid = 1'b1;
    tick(); bus.i_ser_tx_valid = 1'b0;
    tick();
    tick(); bus.i_ser_rx_en = 1'b1; bus.i_ser_rx_nibble = 4'h9;
    @(negedge clk);
    chk("t6_pre_active", 16'(bus.o_ser_tx_active), 16'd1);
    chk("t6_pre_nibble", 16'(bus.o_ser_tx_nibble), 16'hB);
    tick();
    tick(); rst_n = 1'b0;
    @(negedge clk);
    chk("t6_active", 16'(bus.o_ser_tx_active), 16'd0);
    chk("t6_nibble", 16'(bus.o_ser_tx_nibble), 16'd0);
    chk("t6_ready", 16'(bus.o_ser_tx_ready), 16'd1);
    chk("t6_rx_data", bus.o_ser_rx_data, 16'h0000);
    chk("t6_rx_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    tick(); rst_n = 1'b1;
    tick(); bus.i_ser_rx_en = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", 16'(bus.o_ser_rx_valid), 16'd0);
    chk("t6_post_empty", 16'(bus.o_ser_tx_active), 16'd0);
    tick();
    @(negedge clk);
    chk("t6_post_valid2", 16'(bus.o_ser_rx_valid), 16'd0);
    chk("t5_clean", 16'(err), 16'd0);
    // counter skips 1 -> 3
    tick(); ctr = 2'd3; last = 1'b1;
    @(negedge clk); chk("t5_skip_pre", 16'(err), 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk); chk("t5_skip_sticky", 16'(err), 16'd1);
    end
    @(posedge clk);
    #1 rst_n = 1'b0; ctr = 2'd0; last = 1'b0;
    @(negedge clk); chk("t5_rst_clear", 16'(err), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick(); last = 1'b1;
    @(negedge clk); chk("t5_last_pre", 16'(err), 16'd0);
    tick();
    @(negedge clk); chk("t5_last_err", 16'(err), 16'd1);
    tick();
    @(negedge clk); chk("t5_last_sticky", 16'(err), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
